sccb_req_arb: RTL and testbench
===============================

# sccb_req_arb

Two-port request arbiter and sequencer for the SCCB/I2C write driver of the OV7725 camera path. It sits between the driver and two requesters: port 0, the power-up register-table walker, and port 1, the runtime register-write source (exposure, gain and mirror tweaks). It serialises their 16-bit {register address, data} writes onto the driver's single exec/done handshake. It retries NACKed writes, aborts writes that hang, and reports per-request completion and error.

## Interface
Parameters:
- MAX_RETRY, 2: extra attempts after a NACK (total attempts = MAX_RETRY+1); range 0..7.
- TIMEOUT, 16'd4000: clk cycles allowed in WAIT for i2c_done; range 1..65535.
- GAP_CYC, 8'd4: idle cycles inserted after every driver transaction; range 0..255.

Ports:
- clk  in  1  driver clock, connected to the driver's dri_clk output.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request, held with req0_data until req0_ready.
- req0_data  in  16  [15:8] register address, [7:0] write data.
- req0_ready  out  1  one-cycle accept pulse.
- req0_done  out  1  one-cycle completion pulse.
- req0_err  out  1  failure flag, valid only while req0_done=1.
- req1_valid / req1_data / req1_ready / req1_done / req1_err: same widths and rules for port 1.
- i2c_exec  out  1  one-cycle start pulse to the driver.
- i2c_addr  out  8  register address to the driver.
- i2c_data_w  out  8  write data to the driver.
- i2c_done  in  1  driver completion pulse.
- i2c_ack  in  1  driver acknowledge status, sampled with i2c_done: 0 = ACK, 1 = NACK.
- busy  out  1  high in any state except IDLE.

## Operation
- All outputs reset to 0. State resets to IDLE, the round-robin pointer resets to favour port 0, and all counters reset to 0.
- States are IDLE, ISSUE, WAIT, GAP.
- **IDLE**
  - If one port is valid, grant it.
  - If both ports are valid, grant the port not granted last (round-robin).
  - In the grant cycle, pulse that port's ready, latch its data into i2c_addr/i2c_data_w, clear the retry count, and go to ISSUE.
- **ISSUE**
  - Assert i2c_exec for exactly one cycle, clear the timeout counter, and go to WAIT.
- **WAIT**
  - The timeout counter increments each cycle.
  - On i2c_done with i2c_ack=0: pulse done with err=0, then go to GAP.
  - On i2c_done with i2c_ack=1 and retry count < MAX_RETRY: increment the retry count and go to GAP, then on to ISSUE with the same latched data. No done pulse is issued.
  - On i2c_done with i2c_ack=1 and retries exhausted: pulse done with err=1, then go to GAP.
  - If the counter reaches TIMEOUT before i2c_done: pulse done with err=1 and go to GAP. There is no retry after a timeout.
- **GAP**
  - Count GAP_CYC cycles; with GAP_CYC=0, stay one cycle.
  - Exit to ISSUE if a retry is pending, otherwise to IDLE.
- i2c_done outside WAIT is ignored.
- The round-robin pointer updates only on grant.
- reqN_valid dropping before ready is legal; that request is simply not taken.
- A new request on the granted port is not accepted before that port's done pulse plus the gap.

## Timing
- Grant cycle T: ready=1. At T+1: i2c_exec=1. At T+2: WAIT begins.
- done/err are registered, one cycle after the i2c_done cycle.
- Earliest next grant: done cycle + GAP_CYC + 1.
- The i2c_addr/i2c_data_w latch is stable from T+1 until the next grant.
- The timeout fires after exactly TIMEOUT WAIT cycles without i2c_done. An i2c_done arriving in that same cycle wins (success or NACK path).
- Asynchronous reset mid-transaction returns to IDLE with all outputs 0. No done pulse is issued for the aborted request.

## Structure
- Package sccb_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, GAP);
  - the field slice constants ADDR_MSB=15, ADDR_LSB=8, DATA_MSB=7;
  - the port index constants.
- One sub-module, rr_arb2: a 2-requester round-robin grant with a registered last-grant pointer and an update-enable input.
- The retry, timeout and gap counters stay in the top module.

## Test plan
- **Single request:** req0 16'h1234 with the driver acking after 10 cycles -> one i2c_exec, i2c_addr=8'h12, i2c_data_w=8'h34, then req0_done=1 with req0_err=0.
- **Contention:** req0 and req1 valid together, repeatedly -> grants alternate 0,1,0,1. Port 0 goes first after reset. Gaps between transactions are GAP_CYC cycles.
- **NACK then ACK:** NACK, NACK, then ACK with MAX_RETRY=2 -> 3 i2c_exec pulses with identical data, and a single done with err=0.
- **Persistent NACK:** NACK on every attempt with MAX_RETRY=2 -> 3 attempts, then done with err=1, then the other port is serviced.
- **Hung driver:** the driver never returns done with TIMEOUT=100 -> done with err=1 exactly 100 cycles after WAIT entry, and no retry.
- **Reset mid-WAIT:** assert rst_n low during WAIT -> all outputs 0 immediately. After release, a pending req1 is granted before req0.

Source files
------------

// File: rtl/sccb_arb_pkg.sv
// Shared types and constants for the SCCB request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sccb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // {register address, write data} request word layout
    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    // Requester indices: port 0 = power-up table walker, port 1 = runtime tweaks
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with a registered last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the clock edge when upd_en=1.
// Backpressure: none; the caller decides when a grant is consumed via upd_en.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req[1:0]    : request vector, bit N = port N
//   upd_en      : record the current grant as the last one served
//   gnt[1:0]    : one-hot grant (or 0 when no request)
module rr_arb2
    import sccb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic [1:0] gnt
);

    // Port index of the last grant; reset value makes port 0 win the first tie.
    logic last_gnt;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_gnt == PORT1) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= PORT1;
        end else if (upd_en && (gnt != 2'b00)) begin
            last_gnt <= gnt[PORT1];
        end
    end

endmodule

// File: rtl/sccb_req_arb.sv
// Serialises two requesters' {addr,data} writes onto one SCCB driver exec/done handshake, with NACK retry and hang timeout.
// Latency: ready at T, i2c_exec at T+1, WAIT from T+2; reqN_done one cycle after i2c_done (or after TIMEOUT WAIT cycles).
// Backpressure: reqN_ready only in IDLE; after each driver transaction GAP_CYC idle cycles follow the done/retry cycle.
//
// Ports:
//   clk, rst_n                      : driver clock, asynchronous active-low reset
//   reqN_valid/reqN_data/reqN_ready : request handshake, data [15:8] address, [7:0] write data
//   reqN_done/reqN_err              : completion pulse, err valid only with done
//   i2c_exec/i2c_addr/i2c_data_w    : start pulse and latched write to the driver
//   i2c_done/i2c_ack                : driver completion, ack=1 means NACK
//   busy                            : any state other than IDLE
module sccb_req_arb
    import sccb_arb_pkg::*;
#(
    parameter logic [2:0]  MAX_RETRY = 3'd2,
    parameter logic [15:0] TIMEOUT   = 16'd4000,
    parameter logic [7:0]  GAP_CYC   = 8'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        req1_done,
    output logic        req1_err,
    output logic        i2c_exec,
    output logic [7:0]  i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        busy
);

    arb_state_t  state, state_nxt;
    logic        arb_en;
    logic [1:0]  req_vec, gnt;
    logic        grant;
    logic [15:0] sel_dat;
    logic        cur_port;
    logic [2:0]  retry_cnt;
    logic        retry_pend;
    logic [15:0] tcnt;
    logic [7:0]  gcnt;
    logic        nack_retry, fin, fin_err;
    logic [7:0]  addr_q, data_q;
    logic        done0_q, done1_q, err0_q, err1_q;

    // arb_en is low throughout reset and for the first cycle after it, so the
    // combinational ready stays 0 while rst_n is asserted even if requests are up.
    assign req_vec = {req1_valid, req0_valid} & {2{arb_en}};
    assign grant   = (state == IDLE) && (gnt != 2'b00);
    assign sel_dat = gnt[PORT1] ? req1_data : req0_data;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_vec),
        .upd_en (grant),
        .gnt    (gnt)
    );

    // WAIT outcome decode. A driver done in the same cycle the timeout would
    // fire takes priority, so the timeout branch is only reached without done.
    always_comb begin
        nack_retry = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        if (state == WAIT) begin
            if (i2c_done) begin
                if (i2c_ack && (retry_cnt < MAX_RETRY)) begin
                    nack_retry = 1'b1;
                end else begin
                    fin     = 1'b1;
                    fin_err = i2c_ack;
                end
            end else if (tcnt == (TIMEOUT - 16'd1)) begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (fin || nack_retry) state_nxt = GAP;
            // GAP spans the done/retry cycle plus GAP_CYC idle cycles.
            GAP:     if (gcnt == GAP_CYC) state_nxt = retry_pend ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_en     <= 1'b0;
            cur_port   <= PORT0;
            retry_cnt  <= 3'd0;
            retry_pend <= 1'b0;
            tcnt       <= 16'd0;
            gcnt       <= 8'd0;
            addr_q     <= 8'd0;
            data_q     <= 8'd0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            arb_en  <= 1'b1;
            done0_q <= fin && (cur_port == PORT0);
            done1_q <= fin && (cur_port == PORT1);
            err0_q  <= fin && fin_err && (cur_port == PORT0);
            err1_q  <= fin && fin_err && (cur_port == PORT1);
            case (state)
                IDLE: begin
                    if (grant) begin
                        cur_port   <= gnt[PORT1];
                        addr_q     <= sel_dat[ADDR_MSB:ADDR_LSB];
                        data_q     <= sel_dat[DATA_MSB:0];
                        retry_cnt  <= 3'd0;
                        retry_pend <= 1'b0;
                    end
                end
                ISSUE: begin
                    tcnt <= 16'd0;
                end
                WAIT: begin
                    gcnt <= 8'd0;
                    tcnt <= tcnt + 16'd1;
                    if (nack_retry) begin
                        retry_cnt  <= retry_cnt + 3'd1;
                        retry_pend <= 1'b1;
                    end else if (fin) begin
                        retry_pend <= 1'b0;
                    end
                end
                GAP: begin
                    gcnt <= gcnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = grant && gnt[PORT0];
    assign req1_ready = grant && gnt[PORT1];
    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;
    assign i2c_exec   = (state == ISSUE);
    assign i2c_addr   = addr_q;
    assign i2c_data_w = data_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sccb_req_arb.sv
// Directed bench for sccb_req_arb: reset, contention, single write, NACK retry, persistent NACK, hang timeout, reset mid-WAIT.
// Latency: n/a.
// Backpressure: n/a.
module tb_sccb_req_arb;

    localparam int GAP     = 4;
    localparam int TMO     = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req0_done, req0_err;
    logic        req1_ready, req1_done, req1_err;
    logic        i2c_exec;
    logic [7:0]  i2c_addr, i2c_data_w;
    logic        i2c_done, i2c_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exec_cnt = 0;
    int done0_cnt = 0;

    always #5 clk = ~clk;

    sccb_req_arb #(
        .MAX_RETRY (3'd2),
        .TIMEOUT   (16'd100),
        .GAP_CYC   (8'd4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .req1_err   (req1_err),
        .i2c_exec   (i2c_exec),
        .i2c_addr   (i2c_addr),
        .i2c_data_w (i2c_data_w),
        .i2c_done   (i2c_done),
        .i2c_ack    (i2c_ack),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (i2c_exec) exec_cnt++;
        if (req0_done) done0_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return req0_ready;
            1:       return req1_ready;
            2:       return i2c_exec;
            3:       return req0_done;
            4:       return req1_done;
            5:       return req0_ready | req1_ready;
            default: return 1'b0;
        endcase
    endfunction

    // Returns in the first cycle the selected signal is high; n = cycles waited.
    task automatic wait_for(input int which, input int budget, output int n);
        n = 0;
        #1;
        while (!sig(which) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!sig(which)) begin
            checks++;
            errors++;
            $error("FAIL wait_%0d: no event within %0d cycles", which, budget);
        end
    endtask

    // Driver reply: i2c_done high for one cycle, dly cycles from now.
    task automatic respond(input int dly, input logic ack);
        repeat (dly) @(negedge clk);
        i2c_done = 1'b1;
        i2c_ack  = ack;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_ack  = 1'b0;
    endtask

    initial begin
        int          n;
        int          gp;
        int          base;
        logic [15:0] d0, d1, exp_d;

        rst_n      = 1'b0;
        i2c_done   = 1'b0;
        i2c_ack    = 1'b0;
        d0         = 16'hA001;
        d1         = 16'hB002;
        req0_data  = d0;
        req1_data  = d1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;

        // ---- reset state, both requests already pending ----
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",   busy, 0);
        check("rst_exec",   i2c_exec, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_done",   {req0_done, req1_done, req0_err, req1_err}, 0);
        check("rst_addr",   {i2c_addr, i2c_data_w}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- contention: grants alternate 0,1,0,1 with GAP-cycle spacing ----
        for (int k = 0; k < 4; k++) begin
            wait_for(5, 40, n);
            if (k > 0) check("cont_gap", n, GAP + 1);
            gp = req1_ready ? 1 : 0;
            check("cont_grant", gp, k % 2);
            exp_d = (gp == 1) ? d1 : d0;
            @(negedge clk);
            if (gp == 1) d1 = d1 + 16'h0101;
            else         d0 = d0 + 16'h0101;
            req0_data = d0;
            req1_data = d1;
            #1;
            check("cont_exec", i2c_exec, 1);
            check("cont_addr", {i2c_addr, i2c_data_w}, exp_d);
            respond(2, 1'b0);
            #1;
            check("cont_done", (gp == 1) ? req1_done : req0_done, 1);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // ---- i2c_done outside WAIT is ignored ----
        respond(4, 1'b1);
        #1;
        check("stray_done", {req0_done, req1_done, req0_err, req1_err}, 0);
        check("stray_idle", busy, 0);

        // ---- single request, driver acks after 10 cycles ----
        @(negedge clk);
        req0_data  = 16'h1234;
        req0_valid = 1'b1;
        wait_for(0, 10, n);
        check("single_grant_lat", n, 0);
        base = exec_cnt;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("single_exec", i2c_exec, 1);
        check("single_addr", i2c_addr, 8'h12);
        check("single_data", i2c_data_w, 8'h34);
        check("single_ready_pulse", req0_ready, 0);
        @(negedge clk);
        #1;
        check("single_exec_pulse", i2c_exec, 0);
        check("single_busy", busy, 1);
        respond(9, 1'b0);
        #1;
        check("single_done", req0_done, 1);
        check("single_err", req0_err, 0);
        check("single_nexec", exec_cnt - base, 1);
        @(negedge clk);
        #1;
        check("single_done_pulse", req0_done, 0);

        // ---- NACK, NACK, ACK on port 1 ----
        repeat (GAP + 2) @(negedge clk);
        req1_data  = 16'h5A3C;
        req1_valid = 1'b1;
        wait_for(1, 20, n);
        base = exec_cnt;
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("nak_exec", i2c_exec, 1);
        for (int a = 0; a < 3; a++) begin
            check("nak_addr", {i2c_addr, i2c_data_w}, 16'h5A3C);
            respond(3, a < 2);
            #1;
            if (a < 2) begin
                check("nak_nodone", {req1_done, req0_done}, 0);
                wait_for(2, 20, n);
                check("nak_regap", n, GAP + 1);
            end
        end
        check("nak_done", req1_done, 1);
        check("nak_err", req1_err, 0);
        check("nak_execs", exec_cnt - base, 3);

        // ---- persistent NACK on port 0, port 1 queued behind it ----
        repeat (GAP + 2) @(negedge clk);
        req0_data  = 16'h0F0E;
        req0_valid = 1'b1;
        wait_for(0, 20, n);
        base = exec_cnt;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_data  = 16'h2233;
        req1_valid = 1'b1;
        #1;
        check("pn_addr", {i2c_addr, i2c_data_w}, 16'h0F0E);
        for (int a = 0; a < 3; a++) begin
            respond(2, 1'b1);
            #1;
            if (a < 2) begin
                check("pn_nodone", req0_done, 0);
                wait_for(2, 20, n);
            end
        end
        check("pn_done", req0_done, 1);
        check("pn_err", req0_err, 1);
        check("pn_execs", exec_cnt - base, 3);
        wait_for(1, 20, n);
        check("pn_next_gap", n, GAP + 1);

        // ---- hung driver on port 1: timeout, no retry ----
        base = exec_cnt;
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("hung_addr", {i2c_addr, i2c_data_w}, 16'h2233);
        wait_for(4, 300, n);
        check("hung_lat", n, TMO + 1);
        check("hung_err", req1_err, 1);
        repeat (20) @(negedge clk);
        #1;
        check("hung_noretry", exec_cnt - base, 1);
        check("hung_idle", busy, 0);

        // ---- reset mid-WAIT, req1 pending ----
        @(negedge clk);
        req0_data  = 16'h7711;
        req0_valid = 1'b1;
        wait_for(0, 20, n);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_data  = 16'h4455;
        req1_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("rm_busy_pre", busy, 1);
        base  = done0_cnt;
        rst_n = 1'b0;
        #1;
        check("rm_busy", busy, 0);
        check("rm_exec", i2c_exec, 0);
        check("rm_ready", {req0_ready, req1_ready}, 0);
        check("rm_addr", {i2c_addr, i2c_data_w}, 16'h0000);
        check("rm_done", {req0_done, req1_done, req0_err, req1_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for(1, 10, n);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("rm_req1_addr", {i2c_addr, i2c_data_w}, 16'h4455);
        respond(2, 1'b0);
        #1;
        check("rm_req1_done", req1_done, 1);
        wait_for(0, 20, n);
        check("rm_req0_gap", n, GAP + 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("rm_req0_addr", {i2c_addr, i2c_data_w}, 16'h7711);
        respond(2, 1'b0);
        #1;
        check("rm_req0_done", req0_done, 1);
        check("rm_done0_count", done0_cnt - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
